// File: rtl/core_pkg.sv
// Shared register-file writeback types and sizes.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_LU
  } wb_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: arbitrates pipeline writeback against
// long-latency unit results, buffers losing LU results, tracks busy
// destinations and requests a pipeline stall when the buffer starves.
module regfile_wb_arbiter import core_pkg::*; #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_wdata,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_wdata,
  output logic                  lu_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t             fifo_in, fifo_head, sel_req;
  wb_src_e             rf_src, src_next;
  logic                fifo_full, fifo_empty, push, pop;
  logic                wb_sel, lu_acc, lu_keep, byp_sel;
  logic [CNT_W-1:0]    fifo_count, count_next;
  logic [NUM_REGS-1:0] busy, busy_next;
  logic [STV_W-1:0]    starve_cnt, starve_next;
  logic                stall_next, lu_clear;

  assign lu_ready = !rst && !fifo_full;
  assign lu_acc   = lu_valid && lu_ready;
  assign lu_keep  = lu_acc && (lu_rd != '0);
  assign wb_sel   = wb_we && (wb_rd != '0);
  assign pop      = !wb_sel && !fifo_empty;
  assign byp_sel  = !wb_sel && fifo_empty && lu_keep;
  assign push     = lu_keep && !byp_sel;
  assign fifo_in  = '{rd: lu_rd, wdata: lu_wdata};
  assign lu_clear = rf_we && (rf_src == SRC_LU);

  assign rs1_busy = busy[q_rs1];
  assign rs2_busy = busy[q_rs2];
  assign rd_busy  = busy[q_rd];

  sync_fifo #(
    .WIDTH ($bits(wb_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_lu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_in),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Select the write for next cycle: WB, then buffered LU head, then LU bypass.
  always_comb begin
    src_next = SRC_NONE;
    sel_req  = '0;
    if (wb_sel) begin
      src_next = SRC_WB;
      sel_req  = '{rd: wb_rd, wdata: wb_wdata};
    end else if (pop) begin
      src_next = SRC_LU;
      sel_req  = fifo_head;
    end else if (byp_sel) begin
      src_next = SRC_LU;
      sel_req  = fifo_in;
    end
  end

  // Scoreboard update: LU write landing clears, issue sets, set wins on a tie.
  always_comb begin
    busy_next = busy;
    if (lu_clear) busy_next[rf_rd_addr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Starve timer counts down from the limit while the head keeps losing;
  // terminal count (or a full buffer next cycle) raises the stall request.
  always_comb begin
    count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    if (pop || fifo_empty)
      starve_next = STV_W'(STARVE_LIMIT);
    else if (starve_cnt != '0)
      starve_next = starve_cnt - STV_W'(1);
    else
      starve_next = '0;
    stall_next = (starve_next == '0) || (count_next == CNT_W'(FIFO_DEPTH));
  end

  // Registered write port, source tag, scoreboard and stall state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= '0;
      rf_wdata   <= '0;
      rf_src     <= SRC_NONE;
      busy       <= '0;
      starve_cnt <= STV_W'(STARVE_LIMIT);
      stall_req  <= 1'b0;
    end else begin
      rf_we  <= (src_next != SRC_NONE);
      rf_src <= src_next;
      if (src_next != SRC_NONE) begin
        rf_rd_addr <= sel_req.rd;
        rf_wdata   <= sel_req.wdata;
      end
      busy       <= busy_next;
      starve_cnt <= starve_next;
      stall_req  <= stall_next;
    end
  end

  // Re-issuing to a busy register is only legal on the edge its write lands.
  a_no_issue_to_busy: assert property (@(posedge clk) disable iff (rst)
    !(issue_valid && (issue_rd != '0) && busy[issue_rd] &&
      !(lu_clear && (rf_rd_addr == issue_rd))));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for single-cycle
// arbitration plus hand sequences for scoreboard, starvation, full and reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wdata;
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  regfile_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_wdata    (wb_wdata),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_wdata    (lu_wdata),
    .lu_ready    (lu_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .q_rd        (q_rd),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_busy     (rd_busy),
    .stall_req   (stall_req),
    .rf_we       (rf_we),
    .rf_rd_addr  (rf_rd_addr),
    .rf_wdata    (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb_we = 0; wb_rd = 0; wb_wdata = 0;
    lu_valid = 0; lu_rd = 0; lu_wdata = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  initial begin
    vecs[0] = '{1, 5'd3, 32'h11, 1, 5'd7, 32'h22,          1, 1, 5'd3, 32'h11};
    vecs[1] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,           1, 1, 5'd7, 32'h22};
    vecs[2] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,           1, 0, 5'd7, 32'h22};
    vecs[3] = '{1, 5'd0, 32'h55, 1, 5'd0, 32'h66,          1, 0, 5'd7, 32'h22};
    vecs[4] = '{0, 5'd0, 32'h0,  1, 5'd5, 32'hDEADBEEF,    1, 1, 5'd5, 32'hDEADBEEF};
    vecs[5] = '{1, 5'd2, 32'hAA, 0, 5'd0, 32'h0,           1, 1, 5'd2, 32'hAA};
    vecs[6] = '{0, 5'd0, 32'h0,  0, 5'd0, 32'h0,           1, 0, 5'd2, 32'hAA};

    idle();
    q_rs1 = 0; q_rs2 = 0; q_rd = 0;
    rst = 1;
    tick(); tick();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd", rf_rd_addr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_lu_ready_low", lu_ready, 0);
    rst = 0;
    #1;
    chk("post_rst_lu_ready", lu_ready, 1);

    // Table-driven arbitration vectors
    for (int i = 0; i < 7; i++) begin
      wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_wdata = vecs[i].wb_wdata;
      lu_valid = vecs[i].lu_valid; lu_rd = vecs[i].lu_rd; lu_wdata = vecs[i].lu_wdata;
      #1;
      chk($sformatf("v%0d_lu_ready", i), lu_ready, vecs[i].exp_ready);
      tick();
      chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].exp_we);
      chk($sformatf("v%0d_rf_rd", i), rf_rd_addr, vecs[i].exp_rd);
      chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].exp_data);
      chk($sformatf("v%0d_stall", i), stall_req, 0);
    end
    idle();

    // Scoreboard: issue sets, LU write clears one cycle after rf_we
    q_rs1 = 5;
    issue_valid = 1; issue_rd = 5;
    tick();
    issue_valid = 0;
    chk("sb_rs1_busy_set", rs1_busy, 1);
    lu_valid = 1; lu_rd = 5; lu_wdata = 32'hDEADBEEF;
    tick();
    lu_valid = 0;
    chk("sb_lu_rf_we", rf_we, 1);
    chk("sb_lu_rf_rd", rf_rd_addr, 5);
    chk("sb_lu_rf_wdata", rf_wdata, 32'hDEADBEEF);
    chk("sb_busy_still_set", rs1_busy, 1);
    tick();
    chk("sb_busy_cleared", rs1_busy, 0);

    // Same-edge set and clear of rd 9: set wins
    q_rd = 9;
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    chk("sb9_set", rd_busy, 1);
    lu_valid = 1; lu_rd = 9; lu_wdata = 32'h99;
    tick();
    lu_valid = 0;
    chk("sb9_rf_rd", rf_rd_addr, 9);
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    chk("sb9_set_wins", rd_busy, 1);
    lu_valid = 1; lu_rd = 9; lu_wdata = 32'h98;
    tick();
    lu_valid = 0;
    tick();
    chk("sb9_final_clear", rd_busy, 0);
    q_rs2 = 0;
    issue_valid = 1; issue_rd = 0;
    tick();
    issue_valid = 0;
    chk("sb_x0_never_busy", rs2_busy, 0);

    // Starvation: one buffered LU result losing to continuous WB
    wb_we = 1; wb_rd = 1; wb_wdata = 32'h100;
    lu_valid = 1; lu_rd = 12; lu_wdata = 32'hC0C0;
    tick();
    lu_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("starve_c%0d_stall", k), stall_req, 0);
    end
    tick();
    chk("starve_stall_set", stall_req, 1);
    chk("starve_wb_writing", rf_rd_addr, 1);
    wb_we = 0;
    tick();
    chk("starve_drain_rd", rf_rd_addr, 12);
    chk("starve_drain_data", rf_wdata, 32'hC0C0);
    chk("starve_stall_clear", stall_req, 0);
    idle();
    tick();

    // FIFO full: four buffered results, fifth refused
    wb_we = 1; wb_rd = 1; wb_wdata = 32'h200;
    for (int j = 0; j < 4; j++) begin
      lu_valid = 1; lu_rd = 5'(20 + j); lu_wdata = 32'hA000 + j;
      #1;
      chk($sformatf("full_push%0d_ready", j), lu_ready, 1);
      tick();
    end
    chk("full_stall", stall_req, 1);
    lu_valid = 1; lu_rd = 24; lu_wdata = 32'hA004;
    #1;
    chk("full_fifth_ready", lu_ready, 0);
    tick();
    chk("full_stall_hold", stall_req, 1);
    idle();
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("full_drain%0d_we", j), rf_we, 1);
      chk($sformatf("full_drain%0d_rd", j), rf_rd_addr, 20 + j);
      chk($sformatf("full_drain%0d_data", j), rf_wdata, 32'hA000 + j);
      if (j == 0) chk("full_stall_release", stall_req, 0);
    end
    tick();
    chk("full_empty_after", rf_we, 0);

    // Reset with busy bits and FIFO populated
    wb_we = 1; wb_rd = 1; wb_wdata = 32'h300;
    issue_valid = 1; issue_rd = 6;
    lu_valid = 1; lu_rd = 14; lu_wdata = 32'hE14;
    tick();
    issue_valid = 0;
    lu_rd = 15; lu_wdata = 32'hE15;
    tick();
    idle();
    q_rs1 = 6;
    #1;
    chk("pre_rst_busy6", rs1_busy, 1);
    rst = 1;
    #1;
    chk("mid_rst_lu_ready", lu_ready, 0);
    tick();
    rst = 0;
    #1;
    chk("mid_rst_rf_we", rf_we, 0);
    chk("mid_rst_rf_rd", rf_rd_addr, 0);
    chk("mid_rst_rf_wdata", rf_wdata, 0);
    chk("mid_rst_stall", stall_req, 0);
    chk("mid_rst_lu_ready_hi", lu_ready, 1);
    chk("mid_rst_busy6", rs1_busy, 0);
    tick();
    chk("mid_rst_fifo_discarded", rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
